// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//
// Hunts for a fixed sync pattern in a strobed serial bit stream, then collects a
// DATA_W-bit payload MSB-first and, when PARITY_EN is set, checks one trailing
// even-parity bit. A good frame is committed to data_out with a one-cycle
// data_valid pulse and bumps frame_cnt; a parity failure pulses parity_err instead.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   en         in   bit strobe; din sampled only on edges with en=1
//   din        in   serial data bit
//   data_out   out  [DATA_W-1:0] last good payload, MSB = first payload bit
//   data_valid out  one-cycle pulse per good frame
//   parity_err out  one-cycle pulse per frame failing parity
//   busy       out  high in DATA and PARITY states
//   frame_cnt  out  [7:0] good-frame count, wraps 255 -> 0
module serial_frame_deserializer #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        SYNC_W    = 4,
  parameter logic [SYNC_W-1:0]  SYNC_PAT  = 4'b1011,
  parameter bit                 PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    StHunt,
    StData,
    StParity
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   sync_q, sync_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic [SYNC_W-1:0]   sync_shift;
  logic [DATA_W-1:0]   payload_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHunt;
      sync_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sync_d        = sync_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    perr_d        = 1'b0;
    fcnt_d        = fcnt_q;
    sync_shift    = {sync_q[SYNC_W-2:0], din};
    payload_shift = {shift_q[DATA_W-2:0], din};

    if (en) begin
      unique case (state_q)
        StHunt: begin
          // Sliding window: match against the value including this bit.
          if (sync_shift == SYNC_PAT) begin
            state_d = StData;
            sync_d  = '0;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            sync_d = sync_shift;
          end
        end
        StData: begin
          shift_d = payload_shift;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN) begin
              state_d = StParity;
            end else begin
              data_d  = payload_shift;
              valid_d = 1'b1;
              fcnt_d  = fcnt_q + 8'd1;
              state_d = StHunt;
              sync_d  = '0;
            end
          end
        end
        StParity: begin
          // Even parity: payload bits plus parity bit XOR to zero.
          if (^{shift_q, din} == 1'b0) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = StHunt;
          sync_d  = '0;
        end
        default: begin
          state_d = StHunt;
          sync_d  = '0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign busy       = (state_q == StData) || (state_q == StParity);
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer: instance a with parity,
// instance b without. Stimulus pushes the expected frame result; per-instance
// monitors pop and compare whenever a pulse appears.
module tb_serial_frame_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, din = 1'b0;
  logic       en_b = 1'b0, din_b = 1'b0;

  logic [7:0] data_out_a, frame_cnt_a;
  logic       data_valid_a, parity_err_a, busy_a;
  logic [7:0] data_out_b, frame_cnt_b;
  logic       data_valid_b, parity_err_b, busy_b;

  serial_frame_deserializer #(
    .DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .din(din),
    .data_out(data_out_a), .data_valid(data_valid_a), .parity_err(parity_err_a),
    .busy(busy_a), .frame_cnt(frame_cnt_a)
  );

  serial_frame_deserializer #(
    .DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .din(din_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .parity_err(parity_err_b),
    .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] exp_data_a, exp_cnt_a, exp_data_b, exp_cnt_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle; returns 1 time unit after the edge that sampled it.
  task automatic drive(input bit sel_b, input logic e, input logic d);
    if (sel_b) begin
      en_b  = e;
      din_b = d;
    end else begin
      en  = e;
      din = d;
    end
    @(posedge clk);
    #1;
    en   = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic send_bits(input bit sel_b, input logic [31:0] v, input int n, input bit sparse);
    for (int i = n - 1; i >= 0; i--) begin
      if (sparse) repeat (2) drive(sel_b, 1'b0, 1'($urandom_range(0, 1)));
      drive(sel_b, 1'b1, v[i]);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic p);
    exp_t e;
    bit good;
    good = ((^d) ^ p) == 1'b0;
    if (good) begin
      exp_data_a = d;
      exp_cnt_a  = exp_cnt_a + 8'd1;
    end
    e.err  = !good;
    e.data = exp_data_a;
    e.cnt  = exp_cnt_a;
    e.cyc  = cyc;
    q_a.push_back(e);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic p, input bit sparse);
    send_bits(1'b0, 32'hB, 4, sparse);
    send_bits(1'b0, {24'h0, d}, 8, sparse);
    send_bits(1'b0, {31'h0, p}, 1, sparse);
    push_a(d, p);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    en_b  = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    exp_data_a = 8'h00;
    exp_cnt_a  = 8'h00;
    exp_data_b = 8'h00;
    exp_cnt_b  = 8'h00;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (data_valid_a || parity_err_a) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_pulse: valid=%0b err=%0b, required no pulse (t=%0t)",
                 data_valid_a, parity_err_a, $time);
      end else begin
        e = q_a.pop_front();
        check("a_valid", 32'(data_valid_a), 32'(!e.err));
        check("a_parity_err", 32'(parity_err_a), 32'(e.err));
        check("a_data_out", 32'(data_out_a), 32'(e.data));
        check("a_frame_cnt", 32'(frame_cnt_a), 32'(e.cnt));
        check("a_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (data_valid_b || parity_err_b) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_pulse: valid=%0b err=%0b, required no pulse (t=%0t)",
                 data_valid_b, parity_err_b, $time);
      end else begin
        e = q_b.pop_front();
        check("b_valid", 32'(data_valid_b), 32'(!e.err));
        check("b_parity_err", 32'(parity_err_b), 32'(e.err));
        check("b_data_out", 32'(data_out_b), 32'(e.data));
        check("b_frame_cnt", 32'(frame_cnt_b), 32'(e.cnt));
        check("b_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    exp_t e;
    do_reset();
    check("rst_data_out", 32'(data_out_a), 32'h0);
    check("rst_valid", 32'(data_valid_a), 32'h0);
    check("rst_parity_err", 32'(parity_err_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt_a), 32'h0);

    // Good frame A5, even parity bit 0.
    frame_a(8'hA5, 1'b0, 1'b0);

    // Same frame, wrong parity, from a fresh reset.
    do_reset();
    frame_a(8'hA5, 1'b1, 1'b0);

    // Overlapping preamble 1101011, sync completes on bit 7.
    send_bits(1'b0, 32'h6B, 7, 1'b0);
    check("preamble_busy", 32'(busy_a), 32'h1);
    send_bits(1'b0, 32'h3C, 8, 1'b0);
    send_bits(1'b0, 32'h0, 1, 1'b0);
    push_a(8'h3C, 1'b0);

    // Sparse strobe with noise on idle cycles.
    frame_a(8'hA5, 1'b0, 1'b1);

    // Payload containing the sync pattern; three ones so parity bit 1.
    frame_a(8'hB0, 1'b1, 1'b0);
    check("idle_busy", 32'(busy_a), 32'h0);

    // Abort mid-payload with reset.
    send_bits(1'b0, 32'hB, 4, 1'b0);
    send_bits(1'b0, 32'hA, 4, 1'b0);
    check("abort_busy_before", 32'(busy_a), 32'h1);
    do_reset();
    check("abort_busy_after", 32'(busy_a), 32'h0);
    check("abort_frame_cnt", 32'(frame_cnt_a), 32'h0);
    check("abort_data_out", 32'(data_out_a), 32'h0);
    frame_a(8'h5A, 1'b0, 1'b0);

    // 256 back-to-back good frames: count reaches 255 then wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i);
      frame_a(d, ^d, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    check("wrap_frame_cnt", 32'(frame_cnt_a), 32'h0);

    // No-parity instance: valid one cycle after the 8th payload bit.
    send_bits(1'b1, 32'hB, 4, 1'b0);
    send_bits(1'b1, 32'hFF, 8, 1'b0);
    exp_data_b = 8'hFF;
    exp_cnt_b  = exp_cnt_b + 8'd1;
    e.err  = 1'b0;
    e.data = exp_data_b;
    e.cnt  = exp_cnt_b;
    e.cyc  = cyc;
    q_b.push_back(e);

    repeat (5) drive(1'b0, 1'b0, 1'b0);
    check("b_busy_idle", 32'(busy_b), 32'h0);
    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
